// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: fetch PC generator bus (BTB/RAS/backend inputs, I-cache request outputs)
interface fetch_pc_gen_if #(
    parameter int XLEN        = 32,
    parameter int FETCH_WIDTH = 2
);
    localparam int SW = FETCH_WIDTH > 1 ? $clog2(FETCH_WIDTH) : 1;
    logic                        fetch_ready;
    logic                        halt_req;
    logic                        resume;
    logic                        mispredict;
    logic [XLEN-1:0]             actual_target_address;
    logic [FETCH_WIDTH-1:0]      btb_hit;
    logic [FETCH_WIDTH-1:0]      is_ret;
    logic [FETCH_WIDTH*XLEN-1:0] pred_target;
    logic [FETCH_WIDTH*XLEN-1:0] ret_addr;
    logic [XLEN-1:0]             pc;
    logic                        pc_valid;
    logic [FETCH_WIDTH-1:0]      slot_mask;
    logic                        taken_valid;
    logic [SW-1:0]               taken_slot;

    modport master (
        output fetch_ready, halt_req, resume, mispredict, actual_target_address,
               btb_hit, is_ret, pred_target, ret_addr,
        input  pc, pc_valid, slot_mask, taken_valid, taken_slot
    );

    modport slave (
        input  fetch_ready, halt_req, resume, mispredict, actual_target_address,
               btb_hit, is_ret, pred_target, ret_addr,
        output pc, pc_valid, slot_mask, taken_valid, taken_slot
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-group PC generator with handshake, boot/halt FSM and per-slot valid mask
module fetch_pc_gen #(
    parameter int              XLEN         = 32,
    parameter int              FETCH_WIDTH  = 2,
    parameter int              INST_BYTES   = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input logic            CLK,
    input logic            reset,
    fetch_pc_gen_if.slave  bus
);
    localparam int FB = FETCH_WIDTH * INST_BYTES;
    localparam int IB = $clog2(INST_BYTES);
    localparam int SW = FETCH_WIDTH > 1 ? $clog2(FETCH_WIDTH) : 1;

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    state_t                 r_state;
    logic [XLEN-1:0]        r_pc;
    logic                   r_pc_valid;
    logic [SW-1:0]          w_start;
    logic                   w_taken_valid;
    logic [SW-1:0]          w_taken_slot;
    logic [XLEN-1:0]        w_target;
    logic [FETCH_WIDTH-1:0] w_mask;
    logic                   w_fire;
    logic [XLEN-1:0]        w_seq_pc;
    logic [XLEN-1:0]        w_next_pc;

    assign w_start  = SW'((r_pc >> IB) & XLEN'(FETCH_WIDTH - 1));
    assign w_fire   = r_pc_valid && bus.fetch_ready;
    assign w_seq_pc = (r_pc & ~XLEN'(FB - 1)) + XLEN'(FB);

    always_comb begin
        w_taken_valid = 1'b0;
        w_taken_slot  = '0;
        w_target      = '0;
        w_mask        = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (SW'(i) >= w_start && bus.btb_hit[i]) begin
                w_taken_valid = 1'b1;
                w_taken_slot  = SW'(i);
                w_target      = bus.is_ret[i] ? bus.ret_addr[i*XLEN +: XLEN]
                                              : bus.pred_target[i*XLEN +: XLEN];
            end
        end
        for (int i = 0; i < FETCH_WIDTH; i++)
            w_mask[i] = r_pc_valid && SW'(i) >= w_start && (!w_taken_valid || SW'(i) <= w_taken_slot);
    end

    assign w_next_pc = bus.mispredict ? bus.actual_target_address :
                       w_fire         ? (w_taken_valid ? w_target : w_seq_pc) : r_pc;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VECTOR;
            r_pc_valid <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            case (r_state)
                BOOT: begin
                    r_state    <= RUN;
                    r_pc_valid <= 1'b1;
                end
                RUN: if (bus.halt_req) begin
                    r_state    <= HALTED;
                    r_pc_valid <= 1'b0;
                end
                HALTED: if (bus.resume) begin
                    r_state    <= RUN;
                    r_pc_valid <= 1'b1;
                end
                default: begin
                    r_state    <= BOOT;
                    r_pc_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.pc_valid    = r_pc_valid;
    assign bus.slot_mask   = w_mask;
    assign bus.taken_valid = w_taken_valid;
    assign bus.taken_slot  = w_taken_slot;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed checks of fetch_pc_gen with FETCH_WIDTH=2, INST_BYTES=4, RESET_VECTOR=0
module tb_fetch_pc_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    fetch_pc_gen_if #(.XLEN(32), .FETCH_WIDTH(2)) bus ();

    fetch_pc_gen #(.XLEN(32), .FETCH_WIDTH(2), .INST_BYTES(4), .RESET_VECTOR(32'h0)) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_pred;
        bus.btb_hit     = '0;
        bus.is_ret      = '0;
        bus.pred_target = '0;
        bus.ret_addr    = '0;
    endtask

    task automatic goto_pc(input logic [31:0] a);
        bus.mispredict            = 1'b1;
        bus.actual_target_address = a;
        step();
        bus.mispredict            = 1'b0;
        bus.actual_target_address = '0;
    endtask

    task automatic test_reset;
        #2;
        total++; if (bus.pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
        total++; if (bus.pc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.pc_valid); end
        total++; if (bus.slot_mask !== 2'b00) begin bad++; $display("FAIL reset_mask: got %b want 00", bus.slot_mask); end
        total++; if (bus.taken_valid !== 1'b0) begin bad++; $display("FAIL reset_taken: got %b want 0", bus.taken_valid); end
        step();
        reset           = 1'b0;
        bus.fetch_ready = 1'b1;
        #1;
        total++; if (bus.pc_valid !== 1'b0) begin bad++; $display("FAIL boot_valid: got %b want 0", bus.pc_valid); end
    endtask

    task automatic test_sequential;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (bus.pc !== 32'(k * 8)) begin bad++; $display("FAIL seq_pc%0d: got %h want %h", k, bus.pc, 32'(k * 8)); end
            total++; if (bus.pc_valid !== 1'b1) begin bad++; $display("FAIL seq_valid%0d: got %b want 1", k, bus.pc_valid); end
            total++; if (bus.slot_mask !== 2'b11) begin bad++; $display("FAIL seq_mask%0d: got %b want 11", k, bus.slot_mask); end
        end
    endtask

    task automatic test_ret;
        bus.btb_hit     = 2'b11;
        bus.is_ret      = 2'b01;
        bus.ret_addr    = {32'h0000_0500, 32'h0000_0040};
        bus.pred_target = {32'h0000_0600, 32'h0000_0999};
        #1;
        total++; if (bus.taken_valid !== 1'b1) begin bad++; $display("FAIL ret_taken: got %b want 1", bus.taken_valid); end
        total++; if (bus.taken_slot !== 1'b0) begin bad++; $display("FAIL ret_slot: got %b want 0", bus.taken_slot); end
        total++; if (bus.slot_mask !== 2'b01) begin bad++; $display("FAIL ret_mask: got %b want 01", bus.slot_mask); end
        step();
        clear_pred();
        #1;
        total++; if (bus.pc !== 32'h40) begin bad++; $display("FAIL ret_pc: got %h want %h", bus.pc, 32'h40); end
    endtask

    task automatic test_btb;
        goto_pc(32'h8);
        bus.btb_hit     = 2'b10;
        bus.pred_target = {32'h0000_0104, 32'h0000_0777};
        #1;
        total++; if (bus.pc !== 32'h8) begin bad++; $display("FAIL btb_start_pc: got %h want %h", bus.pc, 32'h8); end
        total++; if (bus.taken_slot !== 1'b1 || bus.taken_valid !== 1'b1) begin bad++; $display("FAIL btb_slot: got %b/%b want 1/1", bus.taken_valid, bus.taken_slot); end
        total++; if (bus.slot_mask !== 2'b11) begin bad++; $display("FAIL btb_mask: got %b want 11", bus.slot_mask); end
        step();
        clear_pred();
        bus.btb_hit     = 2'b01;
        bus.pred_target = {32'h0000_0888, 32'h0000_0999};
        #1;
        total++; if (bus.pc !== 32'h104) begin bad++; $display("FAIL btb_target_pc: got %h want %h", bus.pc, 32'h104); end
        total++; if (bus.slot_mask !== 2'b10) begin bad++; $display("FAIL midgroup_mask: got %b want 10", bus.slot_mask); end
        total++; if (bus.taken_valid !== 1'b0) begin bad++; $display("FAIL ineligible_hit: got %b want 0", bus.taken_valid); end
        step();
        clear_pred();
        #1;
        total++; if (bus.pc !== 32'h108) begin bad++; $display("FAIL midgroup_next: got %h want %h", bus.pc, 32'h108); end
        total++; if (bus.slot_mask !== 2'b11) begin bad++; $display("FAIL aligned_mask: got %b want 11", bus.slot_mask); end
    endtask

    task automatic test_stall_mispredict;
        goto_pc(32'h20);
        bus.fetch_ready = 1'b0;
        #1;
        total++; if (bus.pc !== 32'h20 || bus.pc_valid !== 1'b1) begin bad++; $display("FAIL stall1: got %h/%b want 20/1", bus.pc, bus.pc_valid); end
        step();
        total++; if (bus.pc !== 32'h20) begin bad++; $display("FAIL stall2: got %h want %h", bus.pc, 32'h20); end
        bus.mispredict            = 1'b1;
        bus.actual_target_address = 32'h300;
        step();
        bus.mispredict = 1'b0;
        #1;
        total++; if (bus.pc !== 32'h300 || bus.pc_valid !== 1'b1) begin bad++; $display("FAIL stall_redirect: got %h/%b want 300/1", bus.pc, bus.pc_valid); end
        step();
        total++; if (bus.pc !== 32'h300) begin bad++; $display("FAIL stall_hold: got %h want %h", bus.pc, 32'h300); end
        bus.fetch_ready = 1'b1;
    endtask

    task automatic test_halt;
        goto_pc(32'h30);
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        #1;
        total++; if (bus.pc !== 32'h38) begin bad++; $display("FAIL halt_pc: got %h want %h", bus.pc, 32'h38); end
        total++; if (bus.pc_valid !== 1'b0 || bus.slot_mask !== 2'b00) begin bad++; $display("FAIL halt_valid: got %b/%b want 0/00", bus.pc_valid, bus.slot_mask); end
        step();
        total++; if (bus.pc !== 32'h38 || bus.pc_valid !== 1'b0) begin bad++; $display("FAIL halt_hold: got %h/%b want 38/0", bus.pc, bus.pc_valid); end
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        #1;
        total++; if (bus.pc !== 32'h38 || bus.pc_valid !== 1'b1 || bus.slot_mask !== 2'b11) begin bad++; $display("FAIL resume: got %h/%b/%b want 38/1/11", bus.pc, bus.pc_valid, bus.slot_mask); end
    endtask

    task automatic test_wrap;
        goto_pc(32'hFFFF_FFF8);
        #1;
        total++; if (bus.pc !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_top: got %h want %h", bus.pc, 32'hFFFF_FFF8); end
        step();
        total++; if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b1) begin bad++; $display("FAIL wrap_pc: got %h/%b want 0/1", bus.pc, bus.pc_valid); end
    endtask

    task automatic test_reset_in_halt;
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        #1;
        total++; if (bus.pc !== 32'h8 || bus.pc_valid !== 1'b0) begin bad++; $display("FAIL prereset_halt: got %h/%b want 8/0", bus.pc, bus.pc_valid); end
        reset = 1'b1;
        #1;
        total++; if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b0) begin bad++; $display("FAIL async_reset: got %h/%b want 0/0", bus.pc, bus.pc_valid); end
        step();
        reset = 1'b0;
        #1;
        total++; if (bus.pc_valid !== 1'b0) begin bad++; $display("FAIL reboot_boot: got %b want 0", bus.pc_valid); end
        step();
        total++; if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b1) begin bad++; $display("FAIL reboot_run: got %h/%b want 0/1", bus.pc, bus.pc_valid); end
    endtask

    initial begin
        bus.fetch_ready           = 1'b0;
        bus.halt_req              = 1'b0;
        bus.resume                = 1'b0;
        bus.mispredict            = 1'b0;
        bus.actual_target_address = '0;
        clear_pred();
        test_reset();
        test_sequential();
        test_ret();
        test_btb();
        test_stall_mispredict();
        test_halt();
        test_wrap();
        test_reset_in_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
